// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment definitions for the ring scanner.
//   seg_t         - one digit's segment vector, bit7 = a ... bit1 = g, bit0 = h (dp)
//   SEG_A..SEG_H  - bit positions of each segment within seg_t
//   SEG_0/SEG_1   - glyphs for the binary display mode
//   SEG_BLANK     - all segments off
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam int unsigned SEG_A = 7;
    localparam int unsigned SEG_B = 6;
    localparam int unsigned SEG_C = 5;
    localparam int unsigned SEG_D = 4;
    localparam int unsigned SEG_E = 3;
    localparam int unsigned SEG_F = 2;
    localparam int unsigned SEG_G = 1;
    localparam int unsigned SEG_H = 0;

    localparam seg_t SEG_0     = 8'b1111_1100;
    localparam seg_t SEG_1     = 8'b0110_0000;
    localparam seg_t SEG_BLANK = 8'b0000_0000;

endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: digit scan timebase for the multiplexed display.
//   clk, rst     - system clock, asynchronous active-high reset
//   scan_idx     - digit currently being scanned, 0..w_digit-1
//   blank        - high during the anti-ghosting window at the start of each dwell
//   frame_start  - high in the first cycle of every frame (dwell 0 of digit 0),
//                  including the first cycle after reset
module seg7_scan_timer #(
    parameter int unsigned dwell        = 4,
    parameter int unsigned blank_cycles = 1,
    parameter int unsigned w_digit      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [$clog2(w_digit)-1:0] scan_idx,
    output logic                       blank,
    output logic                       frame_start
);

    localparam int unsigned CntW = $clog2(dwell);
    localparam int unsigned IdxW = $clog2(w_digit);
    localparam logic [CntW-1:0] CntLast = CntW'(dwell - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(w_digit - 1);

    logic [CntW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [IdxW-1:0] scan_idx_q, scan_idx_d;

    always_comb begin
        dwell_cnt_d = dwell_cnt_q + 1'b1;
        scan_idx_d  = scan_idx_q;
        if (dwell_cnt_q == CntLast) begin
            dwell_cnt_d = '0;
            scan_idx_d  = (scan_idx_q == IdxLast) ? '0 : scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt_q <= '0;
            scan_idx_q  <= '0;
        end else begin
            dwell_cnt_q <= dwell_cnt_d;
            scan_idx_q  <= scan_idx_d;
        end
    end

    assign scan_idx    = scan_idx_q;
    assign blank       = (32'(dwell_cnt_q) < blank_cycles);
    assign frame_start = (dwell_cnt_q == '0) && (scan_idx_q == '0);

endmodule

// File: rtl/seg7_ring_scanner.sv
// seg7_ring_scanner: shows a shift-register value on a multiplexed 7-segment display.
//   clk, rst  - system clock, asynchronous active-high reset
//   en        - display enable; low blanks both outputs from the next edge
//   mode      - 0 = binary (one '0'/'1' glyph per bit), 1 = ring (one perimeter segment per bit)
//   value     - register state to display, captured once per frame
//   abcdefgh  - registered segment drive, active-high, bit7 = a ... bit0 = dp
//   digit     - registered one-hot digit select, active-high, digit[0] = rightmost
module seg7_ring_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned clk_mhz      = 50,
    parameter int unsigned w_digit      = 8,
    parameter int unsigned w_value      = 8,
    parameter int unsigned scan_khz     = 1,
    parameter int unsigned blank_cycles = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [w_value-1:0] value,
    output logic [7:0]         abcdefgh,
    output logic [w_digit-1:0] digit
);

    localparam int unsigned dwell    = clk_mhz * 1000 / scan_khz;
    localparam int unsigned ring_len = 2 * w_digit + 4;
    localparam int unsigned IdxW     = $clog2(w_digit);

    logic [IdxW-1:0]     scan_idx;
    logic                blank;
    logic                frame_start;

    logic [w_value-1:0]  frame_value_q, frame_value_d;
    logic                frame_mode_q, frame_mode_d;
    seg_t                abcdefgh_q, abcdefgh_d;
    logic [w_digit-1:0]  digit_q, digit_d;

    logic [w_digit-1:0]  bin_bits;
    logic [w_digit-1:0]  bin_present;
    logic [ring_len-1:0] ring_bits;
    seg_t                pattern;

    seg7_scan_timer #(
        .dwell       (dwell),
        .blank_cycles(blank_cycles),
        .w_digit     (w_digit)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .scan_idx   (scan_idx),
        .blank      (blank),
        .frame_start(frame_start)
    );

    // The snapshot is forwarded in its own cycle so the first dwell of a frame
    // already shows the new value even when blank_cycles is 0.
    always_comb begin
        frame_value_d = frame_value_q;
        frame_mode_d  = frame_mode_q;
        if (frame_start) begin
            frame_value_d = value;
            frame_mode_d  = mode;
        end
    end

    // Fit the frame value to the digit count and ring length; missing bits read 0.
    if (w_value >= w_digit) begin : g_bin_trunc
        assign bin_bits    = frame_value_d[w_digit-1:0];
        assign bin_present = '1;
    end else begin : g_bin_pad
        assign bin_bits    = {{(w_digit - w_value){1'b0}}, frame_value_d};
        assign bin_present = {{(w_digit - w_value){1'b0}}, {w_value{1'b1}}};
    end

    if (w_value >= ring_len) begin : g_ring_trunc
        assign ring_bits = frame_value_d[ring_len-1:0];
    end else begin : g_ring_pad
        assign ring_bits = {{(ring_len - w_value){1'b0}}, frame_value_d};
    end

    // Ring order: top edge left to right (a), down the right side (b, c of digit 0),
    // bottom edge right to left (d), up the left side (e, f of the leftmost digit).
    always_comb begin
        pattern = SEG_BLANK;
        for (int unsigned d = 0; d < w_digit; d++) begin
            if (scan_idx == IdxW'(d)) begin
                if (frame_mode_d) begin
                    pattern[SEG_A] = ring_bits[w_digit - 1 - d];
                    pattern[SEG_D] = ring_bits[w_digit + 2 + d];
                    if (d == 0) begin
                        pattern[SEG_B] = ring_bits[w_digit];
                        pattern[SEG_C] = ring_bits[w_digit + 1];
                    end
                    if (d == w_digit - 1) begin
                        pattern[SEG_E] = ring_bits[2 * w_digit + 2];
                        pattern[SEG_F] = ring_bits[2 * w_digit + 3];
                    end
                end else if (bin_present[d]) begin
                    pattern = bin_bits[d] ? SEG_1 : SEG_0;
                end
            end
        end
    end

    always_comb begin
        abcdefgh_d = SEG_BLANK;
        digit_d    = '0;
        if (en && !blank) begin
            abcdefgh_d = pattern;
            digit_d    = {{(w_digit - 1){1'b0}}, 1'b1} << scan_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_value_q <= '0;
            frame_mode_q  <= 1'b0;
            abcdefgh_q    <= SEG_BLANK;
            digit_q       <= '0;
        end else begin
            frame_value_q <= frame_value_d;
            frame_mode_q  <= frame_mode_d;
            abcdefgh_q    <= abcdefgh_d;
            digit_q       <= digit_d;
        end
    end

    assign abcdefgh = abcdefgh_q;
    assign digit    = digit_q;

endmodule
